// File: rtl/uart_tx_sequencer_pkg.sv
// Shared types and helpers for the 8250-style UART transmit sequencer:
// FSM state encoding, LCR field positions and frame-shape helper functions.
package uart_tx_sequencer_pkg;

  localparam int OVERSAMPLE = 16;

  localparam int LCR_WLS_LSB = 0;
  localparam int LCR_WLS_MSB = 1;
  localparam int LCR_STB     = 2;
  localparam int LCR_PEN     = 3;
  localparam int LCR_EPS     = 4;
  localparam int LCR_STICK   = 5;
  localparam int LCR_BRK     = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  // Last tick index of the stop period: 1, 1.5 (5-bit words only) or 2 bit times.
  function automatic logic [4:0] stop_last_tick(input logic stb, input logic [1:0] wls,
                                                input int unsigned os);
    int unsigned n;
    if (!stb)
      n = os;
    else if (wls == 2'd0)
      n = os + os / 2;
    else
      n = 2 * os;
    return 5'(n - 1);
  endfunction

  // Parity over the data bits that are actually sent; stick parity forces ~EPS.
  function automatic logic parity_bit(input logic [7:0] data, input logic [5:0] cfg);
    logic [7:0] masked;
    masked = data & (8'hFF >> (~cfg[LCR_WLS_MSB:LCR_WLS_LSB]));
    if (cfg[LCR_STICK])
      return ~cfg[LCR_EPS];
    return cfg[LCR_EPS] ? ^masked : ~^masked;
  endfunction

endpackage

// File: rtl/uart_tx_sequencer_if.sv
// TX FIFO handshake: show-ahead head byte plus a one-cycle pop strobe.
// The sequencer is the master (it pops), the FIFO is the slave.
interface uart_tx_sequencer_if;

  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_pop;

  modport master (output fifo_pop, input fifo_empty, input fifo_data);
  modport slave  (input fifo_pop, output fifo_empty, output fifo_data);

endinterface

// File: rtl/uart_tx_sequencer_baud_gen.sv
// Oversampled baud tick generator. The active limit is only reloaded at a wrap
// (or an explicit clear), so a divisor write never cuts a running count short.
module uart_baud_gen #(
  parameter int DIV_W = 16
) (
  input  logic             CLK_I,
  input  logic             RST_I,
  input  logic [DIV_W-1:0] divisor,
  input  logic             clear,
  output logic             baud_tick
);

  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_lim;
  logic [DIV_W-1:0] lim_live;
  logic [DIV_W-1:0] cnt_nxt;
  logic [DIV_W-1:0] lim_nxt;
  logic             wrap;

  always_comb begin
    lim_live = (divisor == '0) ? {{(DIV_W-1){1'b0}}, 1'b1} : divisor;
    wrap     = (div_cnt >= div_lim - 1'b1);
    lim_nxt  = div_lim;
    cnt_nxt  = div_cnt + 1'b1;
    if (clear || wrap) begin
      lim_nxt = lim_live;
      cnt_nxt = '0;
    end
  end

  // The tick is registered one step ahead so it is high exactly while div_cnt sits at its terminal value.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      div_cnt   <= '0;
      div_lim   <= lim_live;
      baud_tick <= 1'b0;
    end else begin
      div_cnt   <= cnt_nxt;
      div_lim   <= lim_nxt;
      baud_tick <= (cnt_nxt == lim_nxt - 1'b1);
    end
  end

endmodule

// File: rtl/uart_tx_sequencer.sv
// Transmit-side controller of the UART: pops bytes from the TX FIFO, frames them
// according to the LCR captured at pop time and shifts them out on txd.
module uart_tx_sequencer
  import uart_tx_sequencer_pkg::*;
#(
  parameter int OVERSAMPLE = uart_tx_sequencer_pkg::OVERSAMPLE,
  parameter int DIV_W      = 16
) (
  input  logic                       CLK_I,
  input  logic                       RST_I,
  input  logic [DIV_W-1:0]           divisor,
  input  logic [6:0]                 lcr,
  uart_tx_sequencer_if.master        fifo,
  output logic                       txd,
  output logic                       thre,
  output logic                       temt,
  output logic                       baud_tick
);

  localparam logic [4:0] BIT_LAST = 5'(OVERSAMPLE - 1);

  tx_state_e  state;
  logic [7:0] shift_q;
  logic [5:0] cfg_q;
  logic [4:0] tick_cnt;
  logic [2:0] bit_idx;
  logic       tx_bit;
  logic       pop_q;
  logic       start_frame;
  logic       baud_tick_w;
  logic [2:0] bit_last;
  logic [4:0] stop_last;

  assign start_frame = (state == ST_IDLE) && !fifo.fifo_empty;
  assign bit_last    = 3'd4 + {1'b0, cfg_q[LCR_WLS_MSB:LCR_WLS_LSB]};
  assign stop_last   = stop_last_tick(cfg_q[LCR_STB], cfg_q[LCR_WLS_MSB:LCR_WLS_LSB], OVERSAMPLE);

  uart_baud_gen #(
    .DIV_W (DIV_W)
  ) u_baud_gen (
    .CLK_I     (CLK_I),
    .RST_I     (RST_I),
    .divisor   (divisor),
    .clear     (start_frame),
    .baud_tick (baud_tick_w)
  );

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state    <= ST_IDLE;
      shift_q  <= '0;
      cfg_q    <= '0;
      tick_cnt <= '0;
      bit_idx  <= '0;
      tx_bit   <= 1'b1;
      pop_q    <= 1'b0;
    end else begin
      pop_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_frame) begin
            pop_q    <= 1'b1;
            shift_q  <= fifo.fifo_data;
            cfg_q    <= lcr[5:0];
            tick_cnt <= '0;
            bit_idx  <= '0;
            tx_bit   <= 1'b0;
            state    <= ST_START;
          end
        end
        ST_START: begin
          if (baud_tick_w) begin
            if (tick_cnt == BIT_LAST) begin
              tick_cnt <= '0;
              bit_idx  <= '0;
              tx_bit   <= shift_q[0];
              state    <= ST_DATA;
            end else begin
              tick_cnt <= tick_cnt + 5'd1;
            end
          end
        end
        ST_DATA: begin
          if (baud_tick_w) begin
            if (tick_cnt == BIT_LAST) begin
              tick_cnt <= '0;
              if (bit_idx == bit_last) begin
                if (cfg_q[LCR_PEN]) begin
                  tx_bit <= parity_bit(shift_q, cfg_q);
                  state  <= ST_PARITY;
                end else begin
                  tx_bit <= 1'b1;
                  state  <= ST_STOP;
                end
              end else begin
                bit_idx <= bit_idx + 3'd1;
                tx_bit  <= shift_q[bit_idx + 3'd1];
              end
            end else begin
              tick_cnt <= tick_cnt + 5'd1;
            end
          end
        end
        ST_PARITY: begin
          if (baud_tick_w) begin
            if (tick_cnt == BIT_LAST) begin
              tick_cnt <= '0;
              tx_bit   <= 1'b1;
              state    <= ST_STOP;
            end else begin
              tick_cnt <= tick_cnt + 5'd1;
            end
          end
        end
        // Returning to IDLE costs one cycle before the next pop can be issued.
        ST_STOP: begin
          if (baud_tick_w) begin
            if (tick_cnt == stop_last) begin
              tick_cnt <= '0;
              state    <= ST_IDLE;
            end else begin
              tick_cnt <= tick_cnt + 5'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Break is a live override of the line; the frame keeps advancing underneath it.
  assign txd           = tx_bit & ~lcr[LCR_BRK];
  assign fifo.fifo_pop = pop_q;
  assign thre          = fifo.fifo_empty;
  assign temt          = fifo.fifo_empty && (state == ST_IDLE);
  assign baud_tick     = baud_tick_w;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Self-checking bench for uart_tx_sequencer: literal frame vectors, hand-written
// break/reset/back-to-back sequences and random frames against a bit-list model.
module tb_uart_tx_sequencer;

  logic        CLK_I = 1'b0;
  logic        RST_I;
  logic [15:0] divisor;
  logic [6:0]  lcr;
  logic        txd;
  logic        thre;
  logic        temt;
  logic        baud_tick;

  uart_tx_sequencer_if fifo();

  uart_tx_sequencer #(
    .OVERSAMPLE (16),
    .DIV_W      (16)
  ) dut (
    .CLK_I     (CLK_I),
    .RST_I     (RST_I),
    .divisor   (divisor),
    .lcr       (lcr),
    .fifo      (fifo),
    .txd       (txd),
    .thre      (thre),
    .temt      (temt),
    .baud_tick (baud_tick)
  );

  always #5 CLK_I = ~CLK_I;

  typedef struct {
    logic [7:0]  data;
    logic [6:0]  lcr;
    int          div;
    logic [11:0] bits;
    int          nbits;
    int          stopTicks;
  } vec_t;

  vec_t       vecs[8];
  logic [7:0] fifoQ[$];
  bit         expLv[$];
  int         expDur[$];
  int         checkCount    = 0;
  int         passCount     = 0;
  int         popCount      = 0;
  int         popWhileEmpty = 0;

  task automatic refreshFifo();
    fifo.fifo_empty = (fifoQ.size() == 0);
    fifo.fifo_data  = (fifoQ.size() != 0) ? fifoQ[0] : 8'h00;
  endtask

  // FIFO model: honour the pop strobe seen at the edge, then update the head just after it.
  always @(posedge CLK_I) begin
    logic popNow;
    logic emptyNow;
    popNow   = fifo.fifo_pop;
    emptyNow = fifo.fifo_empty;
    #1;
    if (popNow === 1'b1) begin
      popCount++;
      if (emptyNow)
        popWhileEmpty++;
      else
        void'(fifoQ.pop_front());
    end
    refreshFifo();
  end

  task automatic applyStimulus(input logic [7:0] data);
    fifoQ.push_back(data);
    refreshFifo();
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected)
      passCount++;
    else
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic waitPop(input string name);
    int w = 0;
    while (fifo.fifo_pop !== 1'b1 && w < 400) begin
      @(negedge CLK_I);
      w++;
    end
    checkOutput({name, " pop_seen"}, 32'(fifo.fifo_pop), 1);
  endtask

  // Reference frame built straight from the line format: start, data LSB first, parity, stop.
  task automatic buildFrame(input logic [7:0] data, input logic [5:0] cfg, input int div);
    int nb;
    int ones;
    int bitT;
    int stopT;
    bit par;
    expLv.delete();
    expDur.delete();
    nb   = 5 + int'(cfg[1:0]);
    bitT = 16 * div;
    ones = 0;
    expLv.push_back(1'b0);
    expDur.push_back(bitT);
    for (int i = 0; i < nb; i++) begin
      expLv.push_back(data[i]);
      expDur.push_back(bitT);
      ones += int'(data[i]);
    end
    if (cfg[3]) begin
      if (cfg[5])
        par = !cfg[4];
      else if (cfg[4])
        par = bit'(ones % 2);
      else
        par = bit'(1 - ones % 2);
      expLv.push_back(par);
      expDur.push_back(bitT);
    end
    stopT = !cfg[2] ? 16 : ((nb == 5) ? 24 : 32);
    expLv.push_back(1'b1);
    expDur.push_back(stopT * div);
  endtask

  task automatic vectorToFrame(input vec_t v);
    logic [11:0] b;
    b = v.bits;
    expLv.delete();
    expDur.delete();
    for (int i = 0; i < v.nbits; i++) begin
      expLv.push_back(b[i]);
      expDur.push_back(16 * v.div);
    end
    expLv.push_back(1'b1);
    expDur.push_back(v.stopTicks * v.div);
  endtask

  // Waits for the pop, then checks every cycle of the expected frame plus the idle cycle after it.
  task automatic runFrame(input string name, input int div, input logic expEmpty,
                          input logic [6:0] lcrNext, input int expGap);
    int waited;
    int popCycles;
    int temtHigh;
    int ticks;
    int total;
    int bad;
    waited = 0;
    while (fifo.fifo_pop !== 1'b1 && waited < 400) begin
      @(negedge CLK_I);
      waited++;
    end
    checkOutput({name, " pop_seen"}, 32'(fifo.fifo_pop), 1);
    if (expGap >= 0)
      checkOutput({name, " gap_cycles"}, waited, expGap);
    popCycles = 0;
    temtHigh  = 0;
    ticks     = 0;
    total     = 0;
    for (int i = 0; i < expLv.size(); i++) begin
      bad = 0;
      for (int c = 0; c < expDur[i]; c++) begin
        if (total == 1) begin
          checkOutput({name, " thre_after_pop"}, 32'(thre), 32'(expEmpty));
          lcr = lcrNext;
        end
        if (txd !== expLv[i]) bad++;
        if (fifo.fifo_pop === 1'b1) popCycles++;
        if (temt === 1'b1) temtHigh++;
        if (baud_tick === 1'b1) ticks++;
        total++;
        @(negedge CLK_I);
      end
      checkOutput($sformatf("%s bit%0d bad_cycles", name, i), bad, 0);
    end
    checkOutput({name, " pop_width"}, popCycles, 1);
    checkOutput({name, " temt_in_frame"}, temtHigh, 0);
    checkOutput({name, " baud_ticks"}, ticks, total / div);
    checkOutput({name, " temt_end"}, 32'(temt), 32'(expEmpty));
    checkOutput({name, " txd_idle"}, 32'(txd), 1);
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] simulation hung");
  end

  initial begin
    int popsBefore;
    int cnt;
    int d;
    logic [5:0] cfgA;
    logic [5:0] cfgB;
    logic [7:0] dA;
    logic [7:0] dB;
    bit two;

    // data, lcr, div, line bits (index 0 = start bit), bit count, stop ticks
    vecs[0] = '{8'h55, 7'h03, 1, 12'h0AA, 9, 16};
    vecs[1] = '{8'hA7, 7'h1B, 3, 12'h34E, 10, 16};
    vecs[2] = '{8'hFF, 7'h04, 1, 12'h03E, 6, 24};
    vecs[3] = '{8'hFF, 7'h07, 1, 12'h1FE, 9, 32};
    vecs[4] = '{8'h0F, 7'h0B, 2, 12'h21E, 10, 16};
    vecs[5] = '{8'h00, 7'h2A, 1, 12'h100, 9, 16};
    vecs[6] = '{8'h41, 7'h19, 1, 12'h082, 8, 16};
    vecs[7] = '{8'h2A, 7'h05, 2, 12'h054, 7, 32};

    RST_I   = 1'b1;
    divisor = 16'd1;
    lcr     = 7'h03;
    refreshFifo();
    repeat (3) @(negedge CLK_I);
    checkOutput("reset txd", 32'(txd), 1);
    checkOutput("reset fifo_pop", 32'(fifo.fifo_pop), 0);
    checkOutput("reset baud_tick", 32'(baud_tick), 0);
    checkOutput("reset thre", 32'(thre), 1);
    checkOutput("reset temt", 32'(temt), 1);
    RST_I = 1'b0;
    repeat (2) @(negedge CLK_I);

    for (int k = 0; k < 8; k++) begin
      divisor = 16'(vecs[k].div);
      lcr     = vecs[k].lcr;
      repeat (2) @(negedge CLK_I);
      vectorToFrame(vecs[k]);
      applyStimulus(vecs[k].data);
      runFrame($sformatf("vec%0d", k), vecs[k].div, 1'b1, vecs[k].lcr, -1);
    end

    // Three bytes queued together: frames must follow each other with a single idle cycle.
    divisor = 16'd1;
    lcr     = 7'h03;
    @(negedge CLK_I);
    applyStimulus(8'h01);
    applyStimulus(8'h02);
    applyStimulus(8'h03);
    for (int j = 1; j <= 3; j++) begin
      buildFrame(8'(j), 6'h03, 1);
      runFrame($sformatf("b2b%0d", j), 1, (j == 3), 7'h03, (j == 1) ? -1 : 1);
    end

    // Break raised and dropped in the middle of data bit 0 (a 1).
    @(negedge CLK_I);
    popsBefore = popCount;
    applyStimulus(8'h0F);
    waitPop("brk");
    repeat (20) @(negedge CLK_I);
    lcr = 7'h43;
    #1;
    checkOutput("brk assert txd", 32'(txd), 0);
    repeat (4) @(negedge CLK_I);
    checkOutput("brk hold txd", 32'(txd), 0);
    lcr = 7'h03;
    #1;
    checkOutput("brk release txd", 32'(txd), 1);
    repeat (136) @(negedge CLK_I);
    checkOutput("brk frame end temt", 32'(temt), 1);
    checkOutput("brk frame count", popCount - popsBefore, 1);

    // Break held across a whole frame: the FIFO still drains, the line stays low.
    lcr        = 7'h43;
    popsBefore = popCount;
    applyStimulus(8'h81);
    waitPop("brk_drain");
    cnt = 0;
    for (int c = 0; c < 160; c++) begin
      if (txd !== 1'b0) cnt++;
      @(negedge CLK_I);
    end
    checkOutput("brk_drain high cycles", cnt, 0);
    checkOutput("brk_drain temt", 32'(temt), 1);
    checkOutput("brk_drain pops", popCount - popsBefore, 1);
    lcr = 7'h03;
    #1;
    checkOutput("brk_drain release txd", 32'(txd), 1);

    // Reset pulse in the middle of the data bits drops the frame.
    @(negedge CLK_I);
    popsBefore = popCount;
    applyStimulus(8'hAA);
    waitPop("rst");
    repeat (30) @(negedge CLK_I);
    RST_I = 1'b1;
    @(negedge CLK_I);
    RST_I = 1'b0;
    checkOutput("rst txd", 32'(txd), 1);
    checkOutput("rst baud_tick", 32'(baud_tick), 0);
    checkOutput("rst temt", 32'(temt), 1);
    checkOutput("rst fifo_pop", 32'(fifo.fifo_pop), 0);
    cnt = 0;
    for (int c = 0; c < 200; c++) begin
      if (txd !== 1'b1) cnt++;
      @(negedge CLK_I);
    end
    checkOutput("rst line idle low cycles", cnt, 0);
    checkOutput("rst pops", popCount - popsBefore, 1);

    // A zero divisor behaves as one: a tick on every clock.
    divisor = 16'd0;
    repeat (4) @(negedge CLK_I);
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (baud_tick === 1'b1) cnt++;
      @(negedge CLK_I);
    end
    checkOutput("div0 tick count", cnt, 20);
    buildFrame(8'h3C, 6'h03, 1);
    applyStimulus(8'h3C);
    runFrame("div0 frame", 1, 1'b1, 7'h03, -1);

    // Random frames; LCR is rewritten mid-frame, which only the following frame may see.
    for (int k = 0; k < 10; k++) begin
      d    = int'($urandom_range(1, 3));
      cfgA = 6'($urandom_range(0, 63));
      cfgB = 6'($urandom_range(0, 63));
      dA   = 8'($urandom);
      dB   = 8'($urandom);
      two  = bit'($urandom_range(0, 1));
      divisor = 16'(d);
      lcr     = {1'b0, cfgA};
      @(negedge CLK_I);
      applyStimulus(dA);
      if (two) applyStimulus(dB);
      buildFrame(dA, cfgA, d);
      runFrame($sformatf("rnd%0d", k), d, !two, {1'b0, cfgB}, -1);
      if (two) begin
        buildFrame(dB, cfgB, d);
        runFrame($sformatf("rnd%0d_b2b", k), d, 1'b1, {1'b0, cfgB}, 1);
      end
    end

    checkOutput("pop while empty", popWhileEmpty, 0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
